// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, core FSM states, ALU selects and memory-op decode.
package mu0_pkg;

    localparam logic [3:0] OpLda = 4'd0;
    localparam logic [3:0] OpSto = 4'd1;
    localparam logic [3:0] OpAdd = 4'd2;
    localparam logic [3:0] OpSub = 4'd3;
    localparam logic [3:0] OpJmp = 4'd4;
    localparam logic [3:0] OpJge = 4'd5;
    localparam logic [3:0] OpJne = 4'd6;
    localparam logic [3:0] OpStp = 4'd7;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StHalt  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        AluPass = 2'd0,
        AluAdd  = 2'd1,
        AluSub  = 2'd2
    } alu_op_e;

    typedef struct packed {
        logic is_mem;
        logic is_write;
    } mem_op_t;

    function automatic mem_op_t mem_op_decode(input logic [3:0] op);
        mem_op_t d;
        d.is_mem   = (op == OpLda) || (op == OpSto) || (op == OpAdd) || (op == OpSub);
        d.is_write = (op == OpSto);
        return d;
    endfunction

endpackage

// File: rtl/mu0_alu.sv
// Combinational MU0 accumulator datapath: pass-through, add or subtract, modulo 2^DATA_W.
module mu0_alu
    import mu0_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  alu_op_e           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = i_b;
        case (i_op)
            AluAdd:  o_y = i_a + i_b;
            AluSub:  o_y = i_a - i_b;
            default: o_y = i_b;
        endcase
    end

endmodule

// File: rtl/mu0_mc_core.sv
// Multi-cycle MU0 core: FETCH/EXEC/HALT sequencer driving a req/ack single-port memory bus.
module mu0_mc_core
    import mu0_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] acc,
    output logic              halted,
    output logic              illegal
);

    if (ADDR_W < 1 || ADDR_W > DATA_W - 4) begin : g_bad_params
        $error("mu0_mc_core: ADDR_W must be in 1..DATA_W-4");
    end

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_acc;
    logic              r_illegal;

    state_e            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] w_ir_nxt;
    logic [DATA_W-1:0] w_acc_nxt;
    logic              w_illegal_nxt;
    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    alu_op_e           w_alu_op;
    logic [DATA_W-1:0] w_alu_y;
    logic [3:0]        w_op;
    logic [3:0]        w_fetch_op;
    logic [ADDR_W-1:0] w_opnd;
    mem_op_t           w_dec;

    assign w_op       = r_ir[DATA_W-1 -: 4];
    assign w_fetch_op = mem_rdata[DATA_W-1 -: 4];
    assign w_opnd     = r_ir[ADDR_W-1:0];
    assign w_dec      = mem_op_decode(w_op);

    mu0_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op (w_alu_op),
        .i_a  (r_acc),
        .i_b  (mem_rdata),
        .o_y  (w_alu_y)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_acc_nxt     = r_acc;
        w_illegal_nxt = r_illegal;
        w_req         = 1'b0;
        w_we          = 1'b0;
        w_addr        = r_pc;
        w_alu_op      = AluPass;

        if (w_op == OpAdd) begin
            w_alu_op = AluAdd;
        end else if (w_op == OpSub) begin
            w_alu_op = AluSub;
        end

        case (r_state)
            StFetch: begin
                w_req  = 1'b1;
                w_addr = r_pc;
                if (mem_ack) begin
                    w_ir_nxt    = mem_rdata;
                    w_state_nxt = StExec;
                    // STP leaves pc pointing at itself
                    if (w_fetch_op != OpStp) begin
                        w_pc_nxt = r_pc + ADDR_W'(1);
                    end
                end
            end
            StExec: begin
                if (w_dec.is_mem) begin
                    w_req  = 1'b1;
                    w_we   = w_dec.is_write;
                    w_addr = w_opnd;
                    if (mem_ack) begin
                        w_state_nxt = StFetch;
                        if (!w_dec.is_write) begin
                            w_acc_nxt = w_alu_y;
                        end
                    end
                end else begin
                    w_state_nxt = StFetch;
                    case (w_op)
                        OpJmp: w_pc_nxt = w_opnd;
                        OpJge: if (!r_acc[DATA_W-1]) w_pc_nxt = w_opnd;
                        OpJne: if (r_acc != '0) w_pc_nxt = w_opnd;
                        OpStp: w_state_nxt = StHalt;
                        default: w_illegal_nxt = 1'b1;
                    endcase
                end
            end
            default: begin
                w_state_nxt = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StFetch;
            r_pc      <= '0;
            r_ir      <= '0;
            r_acc     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            r_acc     <= w_acc_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Gate with reset so an in-flight request is withdrawn immediately
    assign mem_req   = w_req & ~reset;
    assign mem_we    = w_we;
    assign mem_addr  = w_addr;
    assign mem_wdata = r_acc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign acc       = r_acc;
    assign halted    = (r_state == StHalt);
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_mu0_mc_core.sv
// Self-checking bench for mu0_mc_core: directed programs plus random programs vs an ISA model.
module tb_mu0_mc_core;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [11:0] pc;
    logic [15:0] ir;
    logic [15:0] acc;
    logic        halted;
    logic        illegal;

    mu0_mc_core #(
        .DATA_W (16),
        .ADDR_W (12)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .ir        (ir),
        .acc       (acc),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: program image plus a write overlay owned by the bus process
    logic [15:0]   img     [4096];
    logic [15:0]   ref_mem [4096];
    logic [15:0]   wr_mem  [4096];
    logic [4095:0] wr_valid;
    logic          mem_clr;
    logic          block_we;
    int            max_delay;
    int            cur_delay;
    int            wait_cnt;
    int            delay_sum;

    assign mem_ack   = mem_req && !(block_we && mem_we) && (wait_cnt >= cur_delay);
    assign mem_rdata = wr_valid[mem_addr] ? wr_mem[mem_addr] : img[mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            wr_valid <= '0;
        end else if (mem_req && mem_ack && mem_we) begin
            wr_mem[mem_addr]   <= mem_wdata;
            wr_valid[mem_addr] <= 1'b1;
        end
        if (reset) begin
            wait_cnt  <= 0;
            delay_sum <= 0;
            cur_delay <= int'($urandom_range(max_delay, 0));
        end else if (mem_req && mem_ack) begin
            delay_sum <= delay_sum + wait_cnt;
            wait_cnt  <= 0;
            cur_delay <= int'($urandom_range(max_delay, 0));
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Bus stability monitor: request fields must not move while waiting for ack
    int          viol;
    logic        p_pend;
    logic        p_we;
    logic [11:0] p_addr;
    logic [15:0] p_wdata;
    initial viol = 0;
    always @(negedge clk) begin
        if (reset) begin
            p_pend <= 1'b0;
        end else begin
            if (p_pend && (!mem_req || mem_we != p_we || mem_addr != p_addr ||
                           (p_we && mem_wdata != p_wdata))) begin
                viol <= viol + 1;
            end
            p_pend  <= mem_req && !mem_ack;
            p_we    <= mem_we;
            p_addr  <= mem_addr;
            p_wdata <= mem_wdata;
        end
    end

    int n_cmp;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd(input logic [11:0] a);
        return wr_valid[a] ? wr_mem[a] : img[a];
    endfunction

    task automatic put(input logic [11:0] a, input logic [15:0] d);
        img[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic begin_reset(input int delay_max);
        @(negedge clk);
        reset     = 1'b1;
        mem_clr   = 1'b1;
        max_delay = delay_max;
        for (int i = 0; i < 4096; i++) begin
            img[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
    endtask

    task automatic end_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check_eq("halted", 32'(halted), 32'd1);
    endtask

    // ISA-level reference: interprets ref_mem one instruction at a time
    task automatic ref_run(output int steps, output logic [15:0] r_acc, output logic [11:0] r_pc,
                           output logic [15:0] r_ir, output bit r_ill, output bit done);
        logic [3:0]  op;
        logic [11:0] a;
        logic [11:0] npc;
        r_acc = 0; r_pc = 0; r_ir = 0; r_ill = 0; done = 0; steps = 0;
        while (!done && steps < 300) begin
            r_ir  = ref_mem[r_pc];
            op    = r_ir[15:12];
            a     = r_ir[11:0];
            npc   = r_pc + 12'd1;
            steps++;
            case (op)
                4'd0: r_acc = ref_mem[a];
                4'd1: ref_mem[a] = r_acc;
                4'd2: r_acc = r_acc + ref_mem[a];
                4'd3: r_acc = r_acc - ref_mem[a];
                4'd4: npc = a;
                4'd5: if (r_acc < 16'h8000) npc = a;
                4'd6: if (r_acc != 0) npc = a;
                4'd7: begin npc = r_pc; done = 1; end
                default: r_ill = 1;
            endcase
            r_pc = npc;
        end
    endtask

    task automatic load_arith();
        put(12'h000, 16'h0100); put(12'h001, 16'h2101); put(12'h002, 16'h3102);
        put(12'h003, 16'h1103); put(12'h004, 16'h7000);
        put(12'h100, 16'd5); put(12'h101, 16'd7); put(12'h102, 16'd2);
    endtask

    int          cyc;
    int          steps;
    int          tries;
    logic [15:0] m_acc;
    logic [11:0] m_pc;
    logic [15:0] m_ir;
    bit          m_ill;
    bit          m_done;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        mem_clr  = 1'b1;
        block_we = 1'b0;
        max_delay = 0;

        // Reset state and first fetch
        begin_reset(0);
        load_arith();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pc", 32'(pc), 32'h0);
        check_eq("rst_acc", 32'(acc), 32'h0);
        check_eq("rst_ir", 32'(ir), 32'h0);
        check_eq("rst_req", 32'(mem_req), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_illegal", 32'(illegal), 32'h0);
        mem_clr = 1'b0;
        reset   = 1'b0;
        #1;
        check_eq("first_req", 32'(mem_req), 32'h1);
        check_eq("first_we", 32'(mem_we), 32'h0);
        check_eq("first_addr", 32'(mem_addr), 32'h0);

        // Arithmetic program, zero-wait memory
        run_to_halt(cyc);
        check_eq("arith_cycles", 32'(cyc), 32'd10);
        check_eq("arith_mem103", 32'(rd(12'h103)), 32'h000A);
        check_eq("arith_acc", 32'(acc), 32'h000A);
        check_eq("arith_pc", 32'(pc), 32'h4);
        check_eq("arith_ir", 32'(ir), 32'h7000);
        check_eq("arith_illegal", 32'(illegal), 32'h0);

        // Countdown loop: LDA 3, SUB 1, JNE back, STO, STP
        begin_reset(0);
        put(12'h000, 16'h0100); put(12'h001, 16'h3101); put(12'h002, 16'h6001);
        put(12'h003, 16'h1102); put(12'h004, 16'h7000);
        put(12'h100, 16'd3); put(12'h101, 16'd1); put(12'h102, 16'hBEEF);
        end_reset();
        run_to_halt(cyc);
        check_eq("loop_cycles", 32'(cyc), 32'd18);
        check_eq("loop_acc", 32'(acc), 32'h0);
        check_eq("loop_mem102", 32'(rd(12'h102)), 32'h0);
        check_eq("loop_pc", 32'(pc), 32'h4);

        // JGE: not taken on negative acc, taken on zero
        begin_reset(0);
        put(12'h000, 16'h0100); put(12'h001, 16'h5005); put(12'h002, 16'h0101);
        put(12'h003, 16'h5006); put(12'h004, 16'h7000); put(12'h005, 16'h7000);
        put(12'h006, 16'h0102); put(12'h007, 16'h7000);
        put(12'h100, 16'h8000); put(12'h101, 16'h0000); put(12'h102, 16'h1234);
        end_reset();
        run_to_halt(cyc);
        check_eq("jge_pc", 32'(pc), 32'h7);
        check_eq("jge_acc", 32'(acc), 32'h1234);
        check_eq("jge_cycles", 32'(cyc), 32'd12);

        // Random wait states on the arithmetic program
        for (int k = 0; k < 3; k++) begin
            begin_reset(3);
            load_arith();
            end_reset();
            run_to_halt(cyc);
            check_eq("wait_cycles", 32'(cyc), 32'(10 + delay_sum));
            check_eq("wait_mem103", 32'(rd(12'h103)), 32'h000A);
            check_eq("wait_acc", 32'(acc), 32'h000A);
            check_eq("wait_pc", 32'(pc), 32'h4);
        end

        // pc wrap through an illegal opcode at 0xFFF, SUB underflow
        begin_reset(1);
        put(12'h000, 16'h6003); put(12'h001, 16'h3100); put(12'h002, 16'h4FFF);
        put(12'h003, 16'h7000); put(12'hFFF, 16'h8000); put(12'h100, 16'd1);
        end_reset();
        run_to_halt(cyc);
        check_eq("wrap_pc", 32'(pc), 32'h3);
        check_eq("wrap_acc", 32'(acc), 32'hFFFF);
        check_eq("wrap_illegal", 32'(illegal), 32'h1);
        check_eq("wrap_cycles", 32'(cyc), 32'(12 + delay_sum));

        // Random programs against the ISA model
        for (int t = 0; t < 8; t++) begin
            tries  = 0;
            m_done = 0;
            while (!m_done && tries < 20) begin
                begin_reset(int'($urandom_range(3, 0)));
                for (int i = 0; i < 15; i++) begin
                    logic [3:0] op;
                    logic [11:0] a;
                    op = 4'($urandom_range(9, 0));
                    if (op == 4'd8) op = 4'($urandom_range(15, 8));
                    if (op == 4'd9) op = 4'd2;
                    if (op <= 4'd3) a = 12'h100 + 12'($urandom_range(15, 0));
                    else if (op <= 4'd6) a = 12'($urandom_range(15, 0));
                    else a = 12'($urandom);
                    put(12'(i), {op, a});
                end
                put(12'h00F, 16'h7000);
                for (int i = 0; i < 16; i++) put(12'h100 + 12'(i), 16'($urandom));
                ref_run(steps, m_acc, m_pc, m_ir, m_ill, m_done);
                tries++;
            end
            end_reset();
            run_to_halt(cyc);
            check_eq("rnd_acc", 32'(acc), 32'(m_acc));
            check_eq("rnd_pc", 32'(pc), 32'(m_pc));
            check_eq("rnd_ir", 32'(ir), 32'(m_ir));
            check_eq("rnd_illegal", 32'(illegal), 32'(m_ill));
            check_eq("rnd_cycles", 32'(cyc), 32'(2 * steps + delay_sum));
            for (int i = 0; i < 16; i++) begin
                check_eq("rnd_mem", 32'(rd(12'h100 + 12'(i))), 32'(ref_mem[12'h100 + 12'(i)]));
            end
        end

        // Reset while a STO request is stalled
        begin_reset(0);
        put(12'h000, 16'h0100); put(12'h001, 16'h1180); put(12'h100, 16'h55AA);
        block_we = 1'b1;
        end_reset();
        cyc = 0;
        while (!(mem_req && mem_we) && cyc < 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check_eq("sto_pending", 32'(mem_req && mem_we), 32'h1);
        repeat (2) @(negedge clk);
        check_eq("sto_still_req", 32'(mem_req), 32'h1);
        check_eq("sto_addr", 32'(mem_addr), 32'h180);
        check_eq("sto_wdata", 32'(mem_wdata), 32'h55AA);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("midrst_req", 32'(mem_req), 32'h0);
        check_eq("midrst_pc", 32'(pc), 32'h0);
        check_eq("midrst_acc", 32'(acc), 32'h0);
        check_eq("midrst_written", 32'(wr_valid[12'h180]), 32'h0);
        check_eq("midrst_mem", 32'(rd(12'h180)), 32'h0);
        block_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_eq("bus_stable", 32'(viol), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
